rx_frame_dec: RTL and testbench
===============================

# rx_frame_dec

Parametrised successor to the fixed 4-byte command decoder in the control receive path. It sits between the UART byte receiver (`rx_vld`/`rx_data`) and the register/command dispatcher. It assembles a frame of N_FIELD payload bytes, with an optional sync header and an optional modulo-256 checksum, under a per-byte (inter-byte) timeout. On success it presents the whole payload with a one-cycle valid strobe; on failure it reports the cause with one-cycle error pulses.

## Interface
- `N_FIELD`, default 4: payload bytes per frame; legal range 1..16.
- `TO_CYC`, default 100000: inter-byte timeout in clk_sys cycles; legal range 2..2^20-1.
- `EN_HDR`, default 1: 1 means the first byte must equal HDR_BYTE and is not stored.
- `HDR_BYTE`, default 8'hA5: sync byte value.
- `EN_CSUM`, default 1: 1 means a checksum byte follows the payload.
- `clk_sys  in  1`: system clock.
- `rst_n  in  1`: reset, asynchronous, active-low. Clock is clk_sys.
- `rx_vld  in  1`: one-cycle strobe, byte available.
- `rx_data  in  8`: received byte.
- `frame_data  out  8*N_FIELD`: last good payload. Byte 0 (first received) is in [7:0].
- `frame_vld  out  1`: one-cycle pulse, new good frame.
- `err_hdr  out  1`: one-cycle pulse, header mismatch.
- `err_csum  out  1`: one-cycle pulse, checksum mismatch.
- `err_tmo  out  1`: one-cycle pulse, inter-byte timeout.
- `busy  out  1`: high while a frame is in progress (S_BODY or S_CSUM).

## Operation
States are S_IDLE, S_BODY, S_CSUM, S_DONE and S_FAIL.
- **S_IDLE, on rx_vld**
  - EN_HDR=1 and byte = HDR_BYTE: go to S_BODY with idx=0.
  - EN_HDR=1 and byte ≠ HDR_BYTE: err_hdr pulses next cycle; stay in S_IDLE.
  - EN_HDR=0: store the byte as field 0, seed sum with it, go to S_BODY with idx=1. If N_FIELD=1, go directly to S_CSUM or S_DONE.
- **S_BODY, on rx_vld**
  - Store the byte in shadow[idx] and do sum += byte (8-bit wrap).
  - When idx = N_FIELD-1: go to S_CSUM if EN_CSUM, else S_DONE. Otherwise idx++.
- **S_CSUM, on rx_vld**
  - Byte = sum: go to S_DONE.
  - Byte ≠ sum: go to S_FAIL with cause csum.
- **S_DONE** (one cycle): copy shadow to frame_data, pulse frame_vld, return to S_IDLE.
- **S_FAIL** (one cycle): pulse the latched cause (err_csum or err_tmo), return to S_IDLE. frame_data is unchanged.
- **Timeout**
  - The 20-bit counter clears on S_IDLE and on every accepted rx_vld, and increments in S_BODY/S_CSUM.
  - When the counter reaches TO_CYC-1 with no rx_vld, go to S_FAIL with cause tmo.
- **Header** bytes never enter the sum. The checksum covers payload bytes only.
- **Error priority:** err_* pulses are mutually exclusive, and never coincide with frame_vld.

## Timing
- **Reset values:** all outputs 0, including frame_data. State is S_IDLE, counter 0, shadow 0, sum 0.
- **Latency:** frame_vld, err_csum and err_tmo assert exactly 2 cycles after the rx_vld of the last byte (or timeout match): one cycle to enter S_DONE/S_FAIL, then a registered pulse. err_hdr is registered and asserts 1 cycle after the bad header's rx_vld.
- frame_data changes only in the same cycle frame_vld is high, and holds until the next good frame.
- **rx_vld together with timeout match:** the byte wins and the counter clears.
- **rx_vld during S_DONE/S_FAIL:** the byte is dropped. Upstream guarantees at least 4 cycles between bytes.
- **busy:** registered decode of state; high from the cycle after the header (or first byte) through the last byte's cycle.
- **Reset mid-frame:** abort immediately. No pulses are generated, and frame_data returns to 0.

## Structure
- Package `rx_frame_pkg` holds:
  - state encoding: 3 bits; IDLE=0, BODY=1, CSUM=2, FAIL=6, DONE=7;
  - fail-cause enum;
  - default HDR_BYTE and TO_CYC constants.
- Sub-module `rx_frame_tmo`: a 20-bit counter with clear/enable inputs and a `hit` output for count = TO_CYC-1.
- Top level: FSM, idx counter (width clog2(N_FIELD)+1), shadow registers, sum, output registers.

## Test plan
- **Good frame, defaults.** Send A5,01,02,03,04,0A → frame_vld pulses once with frame_data=32'h04030201; no err pulses.
- **Bad checksum.** Send A5,01,02,03,04,0B → err_csum pulses once; frame_vld stays 0; frame_data keeps its previous value.
- **Bad header and resync.** Send 5A, then A5,10,20,30,40,A0 → err_hdr pulses once after 5A; the next frame is good with 32'h40302010.
- **Timeout.** Send A5,01, then idle 100000 cycles → err_tmo pulses 2 cycles after counter hit; busy drops. A byte arriving on the hit cycle gives no error.
- **N_FIELD=2, EN_HDR=0, EN_CSUM=0.** Send 33,44 → frame_vld with frame_data=16'h4433. Then send 55 alone and wait TO_CYC → err_tmo.
- **Reset mid-frame.** Send A5,01,02, assert rst_n low → all outputs 0. After release, a full good frame decodes normally.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// Shared types and constants for the framed command receiver.
package rx_frame_pkg;

    // Default sync byte that opens every frame when the header is enabled.
    localparam logic [7:0] DEF_HDR_BYTE = 8'hA5;

    // Default inter-byte timeout in clk_sys cycles.
    localparam int DEF_TO_CYC = 100000;

    // Width of the inter-byte timeout counter.
    localparam int TMO_W = 20;

    // Frame decoder states; FAIL and DONE share the top encoding bits.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BODY = 3'd1,
        S_CSUM = 3'd2,
        S_FAIL = 3'd6,
        S_DONE = 3'd7
    } state_e;

    // Reason a frame was abandoned, reported one cycle after entering S_FAIL.
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_CSUM = 2'd1,
        CAUSE_TMO  = 2'd2
    } cause_e;

endpackage

// File: rtl/rx_frame_tmo.sv
// Inter-byte timeout counter: counts while enabled, clears on request,
// and flags the cycle on which the count equals TO_CYC-1.
module rx_frame_tmo
    import rx_frame_pkg::*;
#(
    parameter int TO_CYC = DEF_TO_CYC
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [TMO_W-1:0] HIT_VAL = TMO_W'(TO_CYC - 1);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Clear has priority over counting so an accepted byte restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == HIT_VAL);

endmodule

// File: rtl/rx_frame_dec.sv
// Frame decoder between the UART byte receiver and the command dispatcher.
// Collects N_FIELD payload bytes behind an optional sync header, checks an
// optional modulo-256 checksum, and reports good frames or failures as
// single-cycle registered pulses.
module rx_frame_dec
    import rx_frame_pkg::*;
#(
    parameter int         N_FIELD  = 4,
    parameter int         TO_CYC   = DEF_TO_CYC,
    parameter bit         EN_HDR   = 1'b1,
    parameter logic [7:0] HDR_BYTE = DEF_HDR_BYTE,
    parameter bit         EN_CSUM  = 1'b1
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic                   rx_vld,
    input  logic [7:0]             rx_data,
    output logic [8*N_FIELD-1:0]   frame_data,
    output logic                   frame_vld,
    output logic                   err_hdr,
    output logic                   err_csum,
    output logic                   err_tmo,
    output logic                   busy
);

    localparam int               IDX_W    = $clog2(N_FIELD) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FIELD - 1);

    state_e               state_q, state_d;
    cause_e               cause_q, cause_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [8*N_FIELD-1:0] shadow_q, shadow_d;
    logic [7:0]           sum_q, sum_d;
    logic [8*N_FIELD-1:0] frame_data_q, frame_data_d;
    logic                 frame_vld_q, frame_vld_d;
    logic                 err_hdr_q, err_hdr_d;
    logic                 err_csum_q, err_csum_d;
    logic                 err_tmo_q, err_tmo_d;
    logic                 busy_q, busy_d;
    logic                 tmo_clr;
    logic                 tmo_en;
    logic                 tmo_hit;

    rx_frame_tmo #(
        .TO_CYC (TO_CYC)
    ) u_tmo (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .clr_i   (tmo_clr),
        .en_i    (tmo_en),
        .hit_o   (tmo_hit)
    );

    // Next-state, datapath updates and output pulse decode for the frame FSM.
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        sum_d        = sum_q;
        frame_data_d = frame_data_q;
        frame_vld_d  = 1'b0;
        err_hdr_d    = 1'b0;
        err_csum_d   = 1'b0;
        err_tmo_d    = 1'b0;
        tmo_clr      = 1'b0;
        tmo_en       = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_clr = 1'b1;
                idx_d   = '0;
                sum_d   = '0;
                cause_d = CAUSE_NONE;
                if (rx_vld) begin
                    if (EN_HDR) begin
                        if (rx_data == HDR_BYTE) begin
                            state_d = S_BODY;
                        end else begin
                            err_hdr_d = 1'b1;
                        end
                    end else begin
                        shadow_d[7:0] = rx_data;
                        sum_d         = rx_data;
                        idx_d         = IDX_W'(1);
                        if (N_FIELD == 1) begin
                            state_d = EN_CSUM ? S_CSUM : S_DONE;
                        end else begin
                            state_d = S_BODY;
                        end
                    end
                end
            end

            S_BODY: begin
                tmo_en = 1'b1;
                if (rx_vld) begin
                    tmo_clr = 1'b1;
                    for (int i = 0; i < N_FIELD; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            shadow_d[8*i +: 8] = rx_data;
                        end
                    end
                    sum_d = sum_q + rx_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = EN_CSUM ? S_CSUM : S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else if (tmo_hit) begin
                    state_d = S_FAIL;
                    cause_d = CAUSE_TMO;
                end
            end

            S_CSUM: begin
                tmo_en = 1'b1;
                if (rx_vld) begin
                    tmo_clr = 1'b1;
                    if (rx_data == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FAIL;
                        cause_d = CAUSE_CSUM;
                    end
                end else if (tmo_hit) begin
                    state_d = S_FAIL;
                    cause_d = CAUSE_TMO;
                end
            end

            S_DONE: begin
                frame_data_d = shadow_q;
                frame_vld_d  = 1'b1;
                state_d      = S_IDLE;
            end

            S_FAIL: begin
                err_csum_d = (cause_q == CAUSE_CSUM);
                err_tmo_d  = (cause_q == CAUSE_TMO);
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_BODY) || (state_d == S_CSUM);
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cause_q      <= CAUSE_NONE;
            idx_q        <= '0;
            shadow_q     <= '0;
            sum_q        <= '0;
            frame_data_q <= '0;
            frame_vld_q  <= 1'b0;
            err_hdr_q    <= 1'b0;
            err_csum_q   <= 1'b0;
            err_tmo_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cause_q      <= cause_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            sum_q        <= sum_d;
            frame_data_q <= frame_data_d;
            frame_vld_q  <= frame_vld_d;
            err_hdr_q    <= err_hdr_d;
            err_csum_q   <= err_csum_d;
            err_tmo_q    <= err_tmo_d;
            busy_q       <= busy_d;
        end
    end

    assign frame_data = frame_data_q;
    assign frame_vld  = frame_vld_q;
    assign err_hdr    = err_hdr_q;
    assign err_csum   = err_csum_q;
    assign err_tmo    = err_tmo_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rx_frame_dec.sv
// Directed testbench for rx_frame_dec: a default-configured instance with a
// short timeout, plus a headerless, checksum-free two-byte instance.
module tb_rx_frame_dec;

    logic        clk_sys;
    logic        rst_n;

    logic        rxVld;
    logic [7:0]  rxData;
    logic [31:0] frameData;
    logic        frameVld, errHdr, errCsum, errTmo, busy;

    logic        rxVld2;
    logic [7:0]  rxData2;
    logic [15:0] frameData2;
    logic        frameVld2, errHdr2, errCsum2, errTmo2, busy2;

    int nCmp  = 0;
    int nFail = 0;

    int nVld = 0, nHdr = 0, nCsum = 0, nTmo = 0;
    int nVld2 = 0, nTmo2 = 0;

    int baseVld, baseHdr, baseCsum, baseTmo;

    rx_frame_dec #(
        .N_FIELD  (4),
        .TO_CYC   (16),
        .EN_HDR   (1'b1),
        .HDR_BYTE (8'hA5),
        .EN_CSUM  (1'b1)
    ) dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .rx_vld     (rxVld),
        .rx_data    (rxData),
        .frame_data (frameData),
        .frame_vld  (frameVld),
        .err_hdr    (errHdr),
        .err_csum   (errCsum),
        .err_tmo    (errTmo),
        .busy       (busy)
    );

    rx_frame_dec #(
        .N_FIELD  (2),
        .TO_CYC   (10),
        .EN_HDR   (1'b0),
        .HDR_BYTE (8'hA5),
        .EN_CSUM  (1'b0)
    ) dut2 (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .rx_vld     (rxVld2),
        .rx_data    (rxData2),
        .frame_data (frameData2),
        .frame_vld  (frameVld2),
        .err_hdr    (errHdr2),
        .err_csum   (errCsum2),
        .err_tmo    (errTmo2),
        .busy       (busy2)
    );

    // Free-running system clock.
    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Pulse counters, sampling the registered outputs at each rising edge.
    always @(posedge clk_sys) begin
        if (frameVld)  nVld++;
        if (errHdr)    nHdr++;
        if (errCsum)   nCsum++;
        if (errTmo)    nTmo++;
        if (frameVld2) nVld2++;
        if (errTmo2)   nTmo2++;
    end

    // Wait gap edges, then strobe one byte; returns 1 time unit after the sampling edge.
    task automatic applyStimulus(input logic [7:0] b, input int gap, input bit toSecond);
        repeat (gap) @(posedge clk_sys);
        #1;
        if (toSecond) begin
            rxVld2  = 1'b1;
            rxData2 = b;
        end else begin
            rxVld  = 1'b1;
            rxData = b;
        end
        @(posedge clk_sys);
        #1;
        rxVld  = 1'b0;
        rxVld2 = 1'b0;
    endtask

    task automatic nextCycle();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic snapshot();
        repeat (4) nextCycle();
        baseVld  = nVld;
        baseHdr  = nHdr;
        baseCsum = nCsum;
        baseTmo  = nTmo;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rxVld   = 1'b0;
        rxData  = 8'h00;
        rxVld2  = 1'b0;
        rxData2 = 8'h00;
        repeat (3) @(posedge clk_sys);
        #1;
        nCmp++; if (frameData !== 32'h0) begin nFail++; $display("[TB] FAIL reset_frame_data: got %h want 00000000", frameData); end
        nCmp++; if ({frameVld, errHdr, errCsum, errTmo, busy} !== 5'b0) begin nFail++; $display("[TB] FAIL reset_flags: got %b want 00000", {frameVld, errHdr, errCsum, errTmo, busy}); end
        nCmp++; if (frameData2 !== 16'h0) begin nFail++; $display("[TB] FAIL reset_frame_data2: got %h want 0000", frameData2); end
        nCmp++; if ({frameVld2, errHdr2, errCsum2, errTmo2, busy2} !== 5'b0) begin nFail++; $display("[TB] FAIL reset_flags2: got %b want 00000", {frameVld2, errHdr2, errCsum2, errTmo2, busy2}); end
        rst_n = 1'b1;
    endtask

    task automatic test_good_frame();
        snapshot();
        applyStimulus(8'hA5, 3, 1'b0);
        nCmp++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL good_busy_hdr: got %b want 1", busy); end
        applyStimulus(8'h01, 3, 1'b0);
        applyStimulus(8'h02, 3, 1'b0);
        applyStimulus(8'h03, 3, 1'b0);
        applyStimulus(8'h04, 3, 1'b0);
        nCmp++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL good_busy_csum: got %b want 1", busy); end
        applyStimulus(8'h0A, 3, 1'b0);
        nCmp++; if (frameVld !== 1'b0) begin nFail++; $display("[TB] FAIL good_vld_early: got %b want 0", frameVld); end
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL good_busy_end: got %b want 0", busy); end
        nextCycle();
        nCmp++; if (frameVld !== 1'b1) begin nFail++; $display("[TB] FAIL good_vld: got %b want 1", frameVld); end
        nCmp++; if (frameData !== 32'h04030201) begin nFail++; $display("[TB] FAIL good_data: got %h want 04030201", frameData); end
        nextCycle();
        nCmp++; if (frameVld !== 1'b0) begin nFail++; $display("[TB] FAIL good_vld_width: got %b want 0", frameVld); end
        repeat (3) nextCycle();
        nCmp++; if (nVld - baseVld !== 1) begin nFail++; $display("[TB] FAIL good_vld_count: got %0d want 1", nVld - baseVld); end
        nCmp++; if ((nHdr - baseHdr) + (nCsum - baseCsum) + (nTmo - baseTmo) !== 0) begin nFail++; $display("[TB] FAIL good_err_count: got %0d want 0", (nHdr - baseHdr) + (nCsum - baseCsum) + (nTmo - baseTmo)); end
    endtask

    task automatic test_bad_csum();
        snapshot();
        applyStimulus(8'hA5, 3, 1'b0);
        applyStimulus(8'h01, 3, 1'b0);
        applyStimulus(8'h02, 3, 1'b0);
        applyStimulus(8'h03, 3, 1'b0);
        applyStimulus(8'h04, 3, 1'b0);
        applyStimulus(8'h0B, 3, 1'b0);
        nCmp++; if (errCsum !== 1'b0) begin nFail++; $display("[TB] FAIL csum_early: got %b want 0", errCsum); end
        nextCycle();
        nCmp++; if (errCsum !== 1'b1) begin nFail++; $display("[TB] FAIL csum_pulse: got %b want 1", errCsum); end
        nCmp++; if (frameVld !== 1'b0) begin nFail++; $display("[TB] FAIL csum_no_vld: got %b want 0", frameVld); end
        nCmp++; if (frameData !== 32'h04030201) begin nFail++; $display("[TB] FAIL csum_data_hold: got %h want 04030201", frameData); end
        repeat (3) nextCycle();
        nCmp++; if (nCsum - baseCsum !== 1) begin nFail++; $display("[TB] FAIL csum_count: got %0d want 1", nCsum - baseCsum); end
        nCmp++; if ((nVld - baseVld) + (nTmo - baseTmo) + (nHdr - baseHdr) !== 0) begin nFail++; $display("[TB] FAIL csum_other_count: got %0d want 0", (nVld - baseVld) + (nTmo - baseTmo) + (nHdr - baseHdr)); end
    endtask

    task automatic test_bad_header();
        snapshot();
        applyStimulus(8'h5A, 3, 1'b0);
        nCmp++; if (errHdr !== 1'b1) begin nFail++; $display("[TB] FAIL hdr_pulse: got %b want 1", errHdr); end
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL hdr_busy: got %b want 0", busy); end
        nextCycle();
        nCmp++; if (errHdr !== 1'b0) begin nFail++; $display("[TB] FAIL hdr_width: got %b want 0", errHdr); end
        applyStimulus(8'hA5, 3, 1'b0);
        applyStimulus(8'h10, 3, 1'b0);
        applyStimulus(8'h20, 3, 1'b0);
        applyStimulus(8'h30, 3, 1'b0);
        applyStimulus(8'h40, 3, 1'b0);
        applyStimulus(8'hA0, 3, 1'b0);
        nextCycle();
        nCmp++; if (frameVld !== 1'b1) begin nFail++; $display("[TB] FAIL resync_vld: got %b want 1", frameVld); end
        nCmp++; if (frameData !== 32'h40302010) begin nFail++; $display("[TB] FAIL resync_data: got %h want 40302010", frameData); end
        repeat (3) nextCycle();
        nCmp++; if (nHdr - baseHdr !== 1) begin nFail++; $display("[TB] FAIL hdr_count: got %0d want 1", nHdr - baseHdr); end
    endtask

    task automatic test_timeout();
        snapshot();
        applyStimulus(8'hA5, 3, 1'b0);
        applyStimulus(8'h01, 3, 1'b0);
        repeat (15) nextCycle();
        nCmp++; if (busy !== 1'b1) begin nFail++; $display("[TB] FAIL tmo_busy_hit: got %b want 1", busy); end
        nCmp++; if (errTmo !== 1'b0) begin nFail++; $display("[TB] FAIL tmo_early_hit: got %b want 0", errTmo); end
        nextCycle();
        nCmp++; if (busy !== 1'b0) begin nFail++; $display("[TB] FAIL tmo_busy_drop: got %b want 0", busy); end
        nCmp++; if (errTmo !== 1'b0) begin nFail++; $display("[TB] FAIL tmo_early_fail: got %b want 0", errTmo); end
        nextCycle();
        nCmp++; if (errTmo !== 1'b1) begin nFail++; $display("[TB] FAIL tmo_pulse: got %b want 1", errTmo); end
        nextCycle();
        nCmp++; if (errTmo !== 1'b0) begin nFail++; $display("[TB] FAIL tmo_width: got %b want 0", errTmo); end
        repeat (3) nextCycle();
        nCmp++; if (nTmo - baseTmo !== 1) begin nFail++; $display("[TB] FAIL tmo_count: got %0d want 1", nTmo - baseTmo); end
        nCmp++; if ((nVld - baseVld) + (nCsum - baseCsum) !== 0) begin nFail++; $display("[TB] FAIL tmo_other_count: got %0d want 0", (nVld - baseVld) + (nCsum - baseCsum)); end
    endtask

    task automatic test_tmo_hit_byte();
        snapshot();
        applyStimulus(8'hA5, 3, 1'b0);
        applyStimulus(8'h11, 3, 1'b0);
        applyStimulus(8'h22, 15, 1'b0);
        applyStimulus(8'h33, 3, 1'b0);
        applyStimulus(8'h44, 3, 1'b0);
        applyStimulus(8'hAA, 3, 1'b0);
        nextCycle();
        nCmp++; if (frameVld !== 1'b1) begin nFail++; $display("[TB] FAIL hitbyte_vld: got %b want 1", frameVld); end
        nCmp++; if (frameData !== 32'h44332211) begin nFail++; $display("[TB] FAIL hitbyte_data: got %h want 44332211", frameData); end
        repeat (3) nextCycle();
        nCmp++; if (nTmo - baseTmo !== 0) begin nFail++; $display("[TB] FAIL hitbyte_tmo_count: got %0d want 0", nTmo - baseTmo); end
    endtask

    task automatic test_no_header();
        int base2Vld;
        int base2Tmo;
        repeat (4) nextCycle();
        base2Vld = nVld2;
        base2Tmo = nTmo2;
        applyStimulus(8'h33, 3, 1'b1);
        nCmp++; if (busy2 !== 1'b1) begin nFail++; $display("[TB] FAIL nohdr_busy: got %b want 1", busy2); end
        applyStimulus(8'h44, 3, 1'b1);
        nCmp++; if (frameVld2 !== 1'b0) begin nFail++; $display("[TB] FAIL nohdr_vld_early: got %b want 0", frameVld2); end
        nextCycle();
        nCmp++; if (frameVld2 !== 1'b1) begin nFail++; $display("[TB] FAIL nohdr_vld: got %b want 1", frameVld2); end
        nCmp++; if (frameData2 !== 16'h4433) begin nFail++; $display("[TB] FAIL nohdr_data: got %h want 4433", frameData2); end
        applyStimulus(8'h55, 3, 1'b1);
        repeat (10) nextCycle();
        nCmp++; if (errTmo2 !== 1'b0) begin nFail++; $display("[TB] FAIL nohdr_tmo_early: got %b want 0", errTmo2); end
        nextCycle();
        nCmp++; if (errTmo2 !== 1'b1) begin nFail++; $display("[TB] FAIL nohdr_tmo_pulse: got %b want 1", errTmo2); end
        nCmp++; if (frameData2 !== 16'h4433) begin nFail++; $display("[TB] FAIL nohdr_data_hold: got %h want 4433", frameData2); end
        repeat (3) nextCycle();
        nCmp++; if (nVld2 - base2Vld !== 1) begin nFail++; $display("[TB] FAIL nohdr_vld_count: got %0d want 1", nVld2 - base2Vld); end
        nCmp++; if (nTmo2 - base2Tmo !== 1) begin nFail++; $display("[TB] FAIL nohdr_tmo_count: got %0d want 1", nTmo2 - base2Tmo); end
    endtask

    task automatic test_reset_mid_frame();
        snapshot();
        applyStimulus(8'hA5, 3, 1'b0);
        applyStimulus(8'h01, 3, 1'b0);
        applyStimulus(8'h02, 3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        nCmp++; if (frameData !== 32'h0) begin nFail++; $display("[TB] FAIL rstmid_data: got %h want 00000000", frameData); end
        nCmp++; if ({frameVld, errHdr, errCsum, errTmo, busy} !== 5'b0) begin nFail++; $display("[TB] FAIL rstmid_flags: got %b want 00000", {frameVld, errHdr, errCsum, errTmo, busy}); end
        nCmp++; if (frameData2 !== 16'h0) begin nFail++; $display("[TB] FAIL rstmid_data2: got %h want 0000", frameData2); end
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        repeat (20) nextCycle();
        nCmp++; if ((nVld - baseVld) + (nHdr - baseHdr) + (nCsum - baseCsum) + (nTmo - baseTmo) !== 0) begin nFail++; $display("[TB] FAIL rstmid_pulses: got %0d want 0", (nVld - baseVld) + (nHdr - baseHdr) + (nCsum - baseCsum) + (nTmo - baseTmo)); end
        applyStimulus(8'hA5, 3, 1'b0);
        applyStimulus(8'h01, 3, 1'b0);
        applyStimulus(8'h02, 3, 1'b0);
        applyStimulus(8'h03, 3, 1'b0);
        applyStimulus(8'h04, 3, 1'b0);
        applyStimulus(8'h0A, 3, 1'b0);
        nextCycle();
        nCmp++; if (frameVld !== 1'b1) begin nFail++; $display("[TB] FAIL rstmid_after_vld: got %b want 1", frameVld); end
        nCmp++; if (frameData !== 32'h04030201) begin nFail++; $display("[TB] FAIL rstmid_after_data: got %h want 04030201", frameData); end
    endtask

    // Run the directed scenarios in order and report.
    initial begin
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_bad_header();
        test_timeout();
        test_tmo_hit_byte();
        test_no_header();
        test_reset_mid_frame();
        repeat (4) nextCycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
